gin_scheduler: RTL and testbench

GIN_SCHEDULER -- requirements
Module: gin_scheduler

---
 rtl/gin_pkg.sv | 26 ++
 rtl/gin_scan_serializer.sv | 56 +++++
 rtl/gin_scheduler.sv | 147 ++++++++++++++
 tb/tb_gin_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gin_pkg.sv
// ---------------------------------------------------------------------------
// gin_pkg
// Shared definitions for the GIN scheduler slice: scheduler state encoding,
// default parameter values and a small width helper.
// ---------------------------------------------------------------------------
package gin_pkg;

  localparam int DEF_BITWIDTH        = 16;
  localparam int DEF_TAG_LENGTH      = 4;
  localparam int DEF_NUM_CONTROLLERS = 10;
  localparam int XFER_CNT_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_FETCH = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gin_scan_serializer.sv
// ---------------------------------------------------------------------------
// gin_scan_serializer
// Holds the controller tag table captured on an accepted start and walks it
// from the highest controller index down to controller 0, one tag per cycle
// while 'active' is high.
//
// Ports
//   clk       : clock, rising edge
//   rstb      : synchronous active-high reset
//   load      : capture cfg_tags and restart the walk at the top controller
//   cfg_tags  : packed tag table, controller i at [i*TAG_LENGTH +: TAG_LENGTH]
//   active    : scheduler is in the programming state
//   scan_tag  : tag of the controller currently addressed (0 when inactive)
//   last      : the walk is at controller 0
// ---------------------------------------------------------------------------
module gin_scan_serializer
  import gin_pkg::*;
#(
  parameter int TAG_LENGTH      = DEF_TAG_LENGTH,
  parameter int NUM_CONTROLLERS = DEF_NUM_CONTROLLERS
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic                                  load,
  input  logic [TAG_LENGTH*NUM_CONTROLLERS-1:0] cfg_tags,
  input  logic                                  active,
  output logic [TAG_LENGTH-1:0]                 scan_tag,
  output logic                                  last
);

  localparam int IDX_W = idx_width(NUM_CONTROLLERS);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_CONTROLLERS - 1);

  logic [TAG_LENGTH*NUM_CONTROLLERS-1:0] tags_q;
  logic [IDX_W-1:0]                      idx_q;

  // NOTE: the tag table is a plain register bank, not a RAM, so clearing it
  // on reset costs nothing and keeps stale configuration from leaking out.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rstb) begin
      tags_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      tags_q <= cfg_tags;
      idx_q  <= IDX_TOP;
    end else if (active && (idx_q != '0)) begin
      idx_q <= idx_q - 1'b1;
    end
  end

  assign last     = (idx_q == '0);
  assign scan_tag = active ? tags_q[int'(idx_q)*TAG_LENGTH +: TAG_LENGTH] : '0;

endmodule

// File: rtl/gin_scheduler.sv
// ---------------------------------------------------------------------------
// gin_scheduler
// Programs NUM_CONTROLLERS GIN multicast controllers over the scan chain,
// then streams num_xfers words from a valid/ready source into the GIN
// delivery port, sustaining one transfer per cycle when both sides allow.
//
// Ports
//   clk, rstb                  : clock, synchronous active-high reset
//   start, abort               : begin a sequence (IDLE only) / abandon it
//   cfg_tags, num_xfers        : configuration, captured on accepted start
//   src_valid/tag/data, ready  : upstream stream
//   gin_program, gin_scan_tag  : scan-chain tag programming
//   gin_enable/tag/value       : GIN delivery, gin_unit_ready completes it
//   busy, done, xfer_count     : status
// ---------------------------------------------------------------------------
module gin_scheduler
  import gin_pkg::*;
#(
  parameter int BITWIDTH        = DEF_BITWIDTH,
  parameter int TAG_LENGTH      = DEF_TAG_LENGTH,
  parameter int NUM_CONTROLLERS = DEF_NUM_CONTROLLERS
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [TAG_LENGTH*NUM_CONTROLLERS-1:0] cfg_tags,
  input  logic [15:0]                           num_xfers,
  input  logic                                  src_valid,
  input  logic [TAG_LENGTH-1:0]                 src_tag,
  input  logic [BITWIDTH-1:0]                   src_data,
  output logic                                  src_ready,
  output logic                                  gin_program,
  output logic [TAG_LENGTH-1:0]                 gin_scan_tag,
  output logic                                  gin_enable,
  output logic [TAG_LENGTH-1:0]                 gin_tag,
  output logic [BITWIDTH-1:0]                   gin_value,
  input  logic                                  gin_unit_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic [15:0]                           xfer_count
);

  state_t                  state, state_next;
  logic [XFER_CNT_W-1:0]   num_q;
  logic [XFER_CNT_W-1:0]   count_inc;
  logic                    more_left;
  logic                    last_xfer;
  logic                    accept_start;
  logic                    xfer_fire;
  logic                    prog_last;

  assign accept_start = (state == S_IDLE) && start && !abort;
  assign xfer_fire    = (state == S_XFER) && gin_unit_ready && !abort;

  // In XFER xfer_count < num_q, so the increment cannot wrap even at 16'hFFFF.
  assign count_inc = xfer_count + 16'd1;
  assign last_xfer = (count_inc == num_q);
  // Widened compare: another word may be pulled only if it is not the last.
  assign more_left = ({1'b0, xfer_count} + 17'd1) < {1'b0, num_q};

  gin_scan_serializer #(
    .TAG_LENGTH      (TAG_LENGTH),
    .NUM_CONTROLLERS (NUM_CONTROLLERS)
  ) u_scan (
    .clk      (clk),
    .rstb     (rstb),
    .load     (accept_start),
    .cfg_tags (cfg_tags),
    .active   (state == S_PROG),
    .scan_tag (gin_scan_tag),
    .last     (prog_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rstb) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic. Abort outranks every transition, including start.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_next = S_PROG;
        S_PROG:  if (prog_last) state_next = (num_q == '0) ? S_DONE : S_FETCH;
        S_FETCH: if (src_valid) state_next = S_XFER;
        S_XFER: begin
          if (gin_unit_ready) begin
            if (last_xfer)                   state_next = S_DONE;
            else if (src_valid && src_ready) state_next = S_XFER;
            else                             state_next = S_FETCH;
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output decode. src_ready is masked by abort so an abandoned sequence
  // never consumes a word it will not deliver.
  always_comb begin
    busy        = 1'b1;
    done        = 1'b0;
    gin_program = 1'b0;
    gin_enable  = 1'b0;
    src_ready   = 1'b0;
    case (state)
      S_IDLE:  busy        = 1'b0;
      S_PROG:  gin_program = 1'b1;
      S_FETCH: src_ready   = !abort;
      S_XFER: begin
        gin_enable = 1'b1;
        src_ready  = !abort && gin_unit_ready && more_left;
      end
      S_DONE:  done        = 1'b1;
      default: busy        = 1'b0;
    endcase
  end

  // Datapath: latched transfer target, delivered count and the word on offer.
  always_ff @(posedge clk) begin
    if (rstb) begin
      num_q      <= '0;
      xfer_count <= '0;
      gin_tag    <= '0;
      gin_value  <= '0;
    end else begin
      if (accept_start) begin
        num_q      <= num_xfers;
        xfer_count <= '0;
      end
      if (xfer_fire) xfer_count <= count_inc;
      if (src_valid && src_ready) begin
        gin_tag   <= src_tag;
        gin_value <= src_data;
      end
    end
  end

endmodule

// File: tb/tb_gin_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gin_scheduler
// Table of sequence scenarios (transfer count, sink stall, source gaps,
// abort point, expected count and done pulses) plus hand-written sequences
// for start-while-busy, abort/start collision and reset priority. Words
// accepted by the DUT are pushed to a scoreboard and popped on delivery.
// ---------------------------------------------------------------------------
module tb_gin_scheduler;

  localparam int BW = 16;
  localparam int TL = 4;
  localparam int NC = 10;

  logic             clk;
  logic             rstb;
  logic             start;
  logic             abort;
  logic [TL*NC-1:0] cfg_tags;
  logic [15:0]      num_xfers;
  logic             src_valid;
  logic [TL-1:0]    src_tag;
  logic [BW-1:0]    src_data;
  logic             src_ready;
  logic             gin_program;
  logic [TL-1:0]    gin_scan_tag;
  logic             gin_enable;
  logic [TL-1:0]    gin_tag;
  logic [BW-1:0]    gin_value;
  logic             gin_unit_ready;
  logic             busy;
  logic             done;
  logic [15:0]      xfer_count;

  gin_scheduler #(
    .BITWIDTH        (BW),
    .TAG_LENGTH      (TL),
    .NUM_CONTROLLERS (NC)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .start          (start),
    .abort          (abort),
    .cfg_tags       (cfg_tags),
    .num_xfers      (num_xfers),
    .src_valid      (src_valid),
    .src_tag        (src_tag),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .gin_program    (gin_program),
    .gin_scan_tag   (gin_scan_tag),
    .gin_enable     (gin_enable),
    .gin_tag        (gin_tag),
    .gin_value      (gin_value),
    .gin_unit_ready (gin_unit_ready),
    .busy           (busy),
    .done           (done),
    .xfer_count     (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int num;
    int stall;
    bit gaps;
    int abort_at;
    int exp_count;
    int exp_done;
  } scn_t;

  typedef struct {
    logic [TL-1:0] tag;
    logic [BW-1:0] data;
  } word_t;

  scn_t  tbl[7];
  word_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [TL-1:0] ctrl_tag(input int s, input int i);
    int v;
    v = (i + 3 * s) % 16;
    return v[TL-1:0];
  endfunction

  function automatic word_t make_word(input int s, input int w);
    word_t r;
    int t, d;
    t = w * 5 + s + 1;
    d = 4096 * (s + 1) + w * 273 + 7;
    r.tag  = t[TL-1:0];
    r.data = d[BW-1:0];
    return r;
  endfunction

  task automatic set_cfg(input int s);
    for (int i = 0; i < NC; i++) cfg_tags[i*TL +: TL] = ctrl_tag(s, i);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"},       busy,         0);
    check({name, "_done"},       done,         0);
    check({name, "_program"},    gin_program,  0);
    check({name, "_scan_tag"},   gin_scan_tag, 0);
    check({name, "_enable"},     gin_enable,   0);
    check({name, "_src_ready"},  src_ready,    0);
    check({name, "_gin_tag"},    gin_tag,      0);
    check({name, "_gin_value"},  gin_value,    0);
    check({name, "_xfer_count"}, xfer_count,   0);
  endtask

  task automatic run_scn(input int s);
    int    widx, fired, prog_cnt, en_cnt, done_cnt, wait_cnt, abort_cyc;
    bit    aborted, finished;
    word_t w;
    widx = 0; fired = 0; prog_cnt = 0; en_cnt = 0; done_cnt = 0; wait_cnt = 0;
    abort_cyc = 0; aborted = 0; finished = 0;
    sb.delete();
    set_cfg(s);
    num_xfers = 16'(tbl[s].num);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0);
      abort = 1'b0;
      w = make_word(s, widx);
      src_tag   = w.tag;
      src_data  = w.data;
      src_valid = tbl[s].gaps ? (cyc % 2 == 1) : 1'b1;
      gin_unit_ready = gin_enable ? (wait_cnt >= tbl[s].stall) : 1'b0;
      if (tbl[s].abort_at >= 0 && !aborted && gin_enable && fired == tbl[s].abort_at) begin
        abort = 1'b1;
        gin_unit_ready = 1'b0;
        aborted = 1'b1;
        abort_cyc = cyc;
      end
      @(negedge clk);
      if (gin_program) begin
        if (prog_cnt < NC) check($sformatf("s%0d_scan_tag%0d", s, prog_cnt), gin_scan_tag,
                                 ctrl_tag(s, NC - 1 - prog_cnt));
        check($sformatf("s%0d_prog_src_ready", s), src_ready, 0);
        prog_cnt++;
      end
      if (gin_enable) begin
        en_cnt++;
        if (sb.size() == 0) begin
          fail_now($sformatf("s%0d_enable_without_word", s));
        end else begin
          check($sformatf("s%0d_gin_tag_w%0d", s, fired), gin_tag, sb[0].tag);
          check($sformatf("s%0d_gin_value_w%0d", s, fired), gin_value, sb[0].data);
          if (gin_unit_ready) begin
            void'(sb.pop_front());
            fired++;
            wait_cnt = 0;
          end else begin
            check($sformatf("s%0d_stall_src_ready", s), src_ready, 0);
            wait_cnt++;
          end
        end
      end
      if (src_valid && src_ready) begin
        sb.push_back(make_word(s, widx));
        widx++;
      end
      if (done) begin
        done_cnt++;
        finished = 1'b1;
      end
      if (aborted && cyc > abort_cyc) begin
        check($sformatf("s%0d_abort_enable", s), gin_enable, 0);
        check($sformatf("s%0d_abort_busy", s), busy, 0);
        check($sformatf("s%0d_abort_src_ready", s), src_ready, 0);
        sb.delete();
        finished = 1'b1;
      end
    end
    if (!finished) fail_now($sformatf("s%0d_timeout", s));
    @(posedge clk); #1;
    start = 1'b0; src_valid = 1'b0; gin_unit_ready = 1'b0;
    @(negedge clk);
    check($sformatf("s%0d_idle_busy", s), busy, 0);
    check($sformatf("s%0d_done_once", s), done, 0);
    check($sformatf("s%0d_xfer_count", s), xfer_count, tbl[s].exp_count);
    check($sformatf("s%0d_done_pulses", s), done_cnt, tbl[s].exp_done);
    check($sformatf("s%0d_prog_cycles", s), prog_cnt, NC);
    check($sformatf("s%0d_delivered", s), fired, tbl[s].exp_count);
    check($sformatf("s%0d_sb_empty", s), sb.size(), 0);
    if (tbl[s].abort_at < 0)
      check($sformatf("s%0d_enable_cycles", s), en_cnt, tbl[s].num * (tbl[s].stall + 1));
  endtask

  initial begin
    int  pc, dc;
    bit  found;

    //          num stall gaps abort exp_cnt exp_done
    tbl[0] = '{0, 0, 1'b0, -1, 0, 1};   // program only
    tbl[1] = '{4, 0, 1'b0, -1, 4, 1};   // streaming
    tbl[2] = '{3, 3, 1'b0, -1, 3, 1};   // sink backpressure
    tbl[3] = '{5, 0, 1'b1, -1, 5, 1};   // source gaps
    tbl[4] = '{5, 0, 1'b0,  2, 2, 0};   // abort after 2 of 5
    tbl[5] = '{3, 0, 1'b0, -1, 3, 1};   // restart after abort
    tbl[6] = '{1, 2, 1'b1, -1, 1, 1};   // single word, gaps and stall

    rstb = 1'b1; start = 1'b0; abort = 1'b0; cfg_tags = '0; num_xfers = '0;
    src_valid = 1'b0; src_tag = '0; src_data = '0; gin_unit_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstb = 1'b0;

    for (int s = 0; s < 7; s++) run_scn(s);

    // start while busy is ignored: config and count stay those of the first start
    set_cfg(0);
    num_xfers = 16'd0;
    pc = 0; dc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0) || (cyc == 4);
      if (cyc == 4) begin
        num_xfers = 16'd7;
        cfg_tags  = '1;
      end
      @(negedge clk);
      if (gin_program) begin
        if (pc < NC) check($sformatf("busy_start_scan_tag%0d", pc), gin_scan_tag, ctrl_tag(0, NC - 1 - pc));
        pc++;
      end
      if (done) begin
        dc++;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_start_prog_cycles", pc, NC);
    check("busy_start_done", dc, 1);
    check("busy_start_idle", busy, 0);

    // abort and start together in IDLE: abort wins
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 0);
    check("abort_start_program", gin_program, 0);

    // reset mid-XFER beats abort, start and gin_unit_ready
    set_cfg(2);
    num_xfers = 16'd3;
    src_valid = 1'b1; gin_unit_ready = 1'b1;
    src_tag = 4'hA; src_data = 16'hBEEF;
    found = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0);
      @(negedge clk);
      if (gin_enable && xfer_count == 16'd1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("reset_xfer_never_reached");
    @(posedge clk); #1;
    rstb = 1'b1; abort = 1'b1; start = 1'b1; gin_unit_ready = 1'b1;
    @(negedge clk);
    check("pre_reset_xfer_count", xfer_count, 2);
    @(posedge clk); #1;
    rstb = 1'b0; abort = 1'b0; start = 1'b0; src_valid = 1'b0; gin_unit_ready = 1'b0;
    @(negedge clk);
    check_all_zero("reset_xfer");

    // reset mid-PROG beats start
    set_cfg(1);
    num_xfers = 16'd2;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0);
    end
    @(negedge clk);
    check("pre_reset_prog", gin_program, 1);
    @(posedge clk); #1;
    rstb = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rstb = 1'b0; start = 1'b0;
    @(negedge clk);
    check_all_zero("reset_prog");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
